// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and lane geometry.
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  // True for the reserved size or an access not aligned to its own size.
  function automatic logic is_bad_access(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extraction/extension and store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  assign shifted = old_word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = old_word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = old_word;
    endcase
  end

  // Each byte lane takes new data when the access covers it, otherwise keeps the old byte.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int HALF_SRC = (gi % 2) * BYTE_W;
      logic       lane_hit;
      logic [7:0] lane_src;

      assign lane_hit = (size == SZ_BYTE) ? (addr_lo == LANE) :
                        (size == SZ_HALF) ? (addr_lo[1] == LANE[1]) : 1'b1;
      assign lane_src = (size == SZ_BYTE) ? new_data[7:0] :
                        (size == SZ_HALF) ? new_data[HALF_SRC +: BYTE_W] :
                                            new_data[gi*BYTE_W +: BYTE_W];
      assign store_word[gi*BYTE_W +: BYTE_W] = lane_hit ? lane_src : old_word[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in flight, sub-word stores via read-modify-write.
// Optional range checking of the word index is enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout
);

  lsu_state_e        state_reg, state_next;
  lsu_size_e         req_size_e;
  logic              accept;
  logic              req_bad;
  logic [ADDR_W-1:0] req_index;

  logic              req_ready_reg, req_ready_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [31:0]       resp_rdata_reg, resp_rdata_next;
  logic              resp_err_reg, resp_err_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_din_reg, mem_din_next;
  logic              mem_we_reg, mem_we_next;

  logic              we_reg;
  lsu_size_e         size_reg;
  logic              unsigned_reg;
  logic [1:0]        addr_lo_reg;
  logic [31:0]       wdata_reg;

  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign req_size_e = lsu_size_e'(req_size);
  assign accept     = req_valid && req_ready_reg;
  assign req_index  = {2'b00, req_addr[ADDR_W-1:2]};

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_bad = is_bad_access(req_size_e, req_addr[1:0]) || (req_index >= ADDR_W'(MEM_SIZE));
`else
  // Range is not enforced; out-of-range indices are driven to memory as-is.
  logic unused_range;
  assign unused_range = (req_index >= ADDR_W'(MEM_SIZE));
  assign req_bad      = is_bad_access(req_size_e, req_addr[1:0]);
`endif

  lsu_lane_align u_lane_align (
    .addr_lo     (addr_lo_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .old_word    (mem_dout),
    .new_data    (wdata_reg),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_bad)                          state_next = RESP;
          else if (req_we && req_size_e == SZ_WORD) state_next = WRITE;
          else                                  state_next = READ;
        end
      end
      READ:    state_next = DATA;
      DATA:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = resp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // Output values are decided one cycle ahead so every interface signal leaves a flop.
  always_comb begin
    req_ready_next  = (state_next == IDLE);
    resp_valid_next = (state_next == RESP);
    mem_we_next     = (state_next == WRITE);
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    mem_addr_next   = mem_addr_reg;
    mem_din_next    = mem_din_reg;
    if (state_reg == IDLE && accept) begin
      mem_addr_next   = req_index;
      mem_din_next    = req_wdata;
      resp_rdata_next = 32'h0;
      resp_err_next   = req_bad;
    end else if (state_reg == DATA) begin
      if (we_reg) mem_din_next    = store_word;
      else        resp_rdata_next = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= 32'h0;
      mem_we_reg     <= 1'b0;
      we_reg         <= 1'b0;
      size_reg       <= SZ_BYTE;
      unsigned_reg   <= 1'b0;
      addr_lo_reg    <= 2'b00;
      wdata_reg      <= 32'h0;
    end else begin
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      mem_addr_reg   <= mem_addr_next;
      mem_din_reg    <= mem_din_next;
      mem_we_reg     <= mem_we_next;
      if (state_reg == IDLE && accept) begin
        we_reg       <= req_we;
        size_reg     <= req_size_e;
        unsigned_reg <= req_unsigned;
        addr_lo_reg  <= req_addr[1:0];
        wdata_reg    <= req_wdata;
      end
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign mem_we     = mem_we_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level memory model.
module tb_load_store_unit;

  localparam int MEM_SIZE = 1024;
  localparam int ADDR_W   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [31:0]       mem_dout = 32'h0;

  load_store_unit #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_dout     (mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port memory: registered read, read-during-write returns old data.
  logic [31:0] dmem [MEM_SIZE] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we && mem_addr < MEM_SIZE) dmem[mem_addr[9:0]] <= mem_din;
    mem_dout <= (mem_addr < MEM_SIZE) ? dmem[mem_addr[9:0]] : 32'h0;
  end

  logic [31:0] ref_mem [MEM_SIZE] = '{default: 32'h0};

  int          n_pass = 0;
  int          n_total = 0;
  int          we_total = 0;
  logic        chk_en = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_writes = 1'b0;
  logic [31:0] exp_idx = 32'h0;
  logic [31:0] exp_wword = 32'h0;
  int          txn_no = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: what a request must produce, from size/alignment rules and word memory.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic e, output logic [31:0] rd, output logic wr,
                                output logic [31:0] ww, output int lat);
    logic [31:0] idx, old, mask, v;
    int sh;
    idx = addr >> 2;
    sh  = 8 * int'(addr[1:0]);
    e   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
    if (idx >= MEM_SIZE) e = 1'b1;
`endif
    old  = (idx < MEM_SIZE) ? ref_mem[idx[9:0]] : 32'h0;
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    rd = 32'h0; wr = 1'b0; ww = old;
    if (e) begin
      lat = 1;
    end else if (we) begin
      wr  = 1'b1;
      ww  = (old & ~(mask << sh)) | ((wdata & mask) << sh);
      lat = (size == 2'd2) ? 2 : 4;
    end else begin
      v = (old >> sh) & mask;
      if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd  = v;
      lat = 3;
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] got_rdata, output logic got_err, output int got_lat);
    logic        e, wr;
    logic [31:0] rd, ww, obs_addr, idx;
    int          lat_exp, waitc, we_before;
    model(we, size, uns, addr, wdata, e, rd, wr, ww, lat_exp);
    idx        = addr >> 2;
    exp_err    = e;
    exp_rdata  = rd;
    exp_writes = wr;
    exp_idx    = idx;
    exp_wword  = ww;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    chk_en    = 1'b1;
    we_before = we_total;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    obs_addr  = mem_addr;
    got_lat   = 1;
    while (!resp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    chk("latency", 32'(got_lat), 32'(lat_exp));
    got_rdata = resp_rdata;
    got_err   = resp_err;
    if (!e) chk("mem_addr_index", obs_addr, idx);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, got_rdata);
      chk("hold_ready_low", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_dropped", 32'(resp_valid), 32'd0);
    chk("we_pulses", 32'(we_total - we_before), 32'(wr));
    if (wr && idx < MEM_SIZE) ref_mem[idx[9:0]] = ww;
    if (idx < MEM_SIZE) chk("mem_word", dmem[idx[9:0]], ref_mem[idx[9:0]]);
    chk_en = 1'b0;
    $display("txn %0d we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             txn_no, we, size, uns, addr, wdata, got_rdata, got_err, got_lat);
    txn_no++;
  endtask

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          we_snap;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (mem_we) begin
            we_total++;
            chk("mem_we_expected", 32'(chk_en & exp_writes), 32'd1);
            if (chk_en) begin
              chk("wr_addr", mem_addr, exp_idx);
              chk("wr_data", mem_din, exp_wword);
            end
          end
          if (chk_en && resp_valid) begin
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_err", 32'(resp_err), 32'(exp_err));
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, r_data, r_err, r_lat);
    chk("lit_wstore_lat", 32'(r_lat), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r_data, r_err, r_lat);
    chk("lit_wload_data", r_data, 32'hDEAD_BEEF);
    chk("lit_wload_err", 32'(r_err), 32'd0);
    chk("lit_wload_lat", 32'(r_lat), 32'd3);

    // Byte store into an existing word
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0, r_data, r_err, r_lat);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 0, r_data, r_err, r_lat);
    chk("lit_bstore_lat", 32'(r_lat), 32'd4);
    chk("lit_bstore_mem", dmem[4], 32'hA522_3344);

    // Sub-word loads
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, r_data, r_err, r_lat);
    chk("lit_sbyte", r_data, 32'hFFFF_FFA5);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, r_data, r_err, r_lat);
    chk("lit_ubyte", r_data, 32'h0000_00A5);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, r_data, r_err, r_lat);
    chk("lit_shalf", r_data, 32'hFFFF_A522);

    // Error cases
    we_snap = we_total;
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, r_data, r_err, r_lat);
    chk("lit_err_half", 32'(r_err), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h1234_5678, 0, r_data, r_err, r_lat);
    chk("lit_err_word", 32'(r_err), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, r_data, r_err, r_lat);
    chk("lit_err_rsvd", 32'(r_err), 32'd1);
    chk("lit_err_rdata", r_data, 32'h0);
    chk("lit_err_lat", 32'(r_lat), 32'd1);
    chk("lit_err_no_we", 32'(we_total - we_snap), 32'd0);

    // Back-pressure on the response
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, r_data, r_err, r_lat);
    chk("lit_hold_data", r_data, 32'hA522_3344);

    // Reset in the middle of a sub-word store (DATA phase)
    we_snap = we_total;
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h13; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_rdata", resp_rdata, 32'h0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_mem_din", mem_din, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_mem_kept", dmem[4], 32'hA522_3344);
    chk("mid_rst_no_we", 32'(we_total - we_snap), 32'd0);
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    $display("txn %0d reset during sub-word store, word4=%h", txn_no, dmem[4]);
    txn_no++;

    // Word index beyond memory size
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, r_data, r_err, r_lat);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("lit_oob_err", 32'(r_err), 32'd1);
`else
    chk("lit_oob_err", 32'(r_err), 32'd0);
`endif

    // Randomized traffic over a small window of words
    for (int t = 0; t < 80; t++) begin
      logic        we, uns;
      logic [1:0]  size, lo;
      logic [31:0] addr, wd;
      int          hold;
      we   = 1'($urandom % 2);
      uns  = 1'($urandom % 2);
      size = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      lo   = 2'($urandom % 4);
      if (size == 2'd1 && ($urandom % 2) == 0) lo[0] = 1'b0;
      if (size == 2'd2 && ($urandom % 10) < 7) lo = 2'b00;
      addr = {26'h0, 4'($urandom % 8), lo};
      wd   = $urandom;
      hold = int'($urandom % 3);
      do_req(we, size, uns, addr, wd, hold, r_data, r_err, r_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
